// File: rtl/fetch_unit_pkg.sv
// Shared IF-stage definitions: fetch state encoding, the bubble word and the IF/ID payload.
// The hazard and ID logic import this package too.
package fetch_unit_pkg;

    localparam logic [1:0] ST_REQ   = 2'd0;
    localparam logic [1:0] ST_HELD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // sll $0,$0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    function automatic if_id_t make_if_id(input logic [31:0] instr,
                                          input logic [31:0] pc4,
                                          input logic        valid);
        if_id_t r;
        r.instr = instr;
        r.pc4   = pc4;
        r.valid = valid;
        return r;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, fetches over a req/ack handshake and drives the enable-less IF/ID register,
// presenting a NOP on bubbles/flushes and the previous word on stalls.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = NOP_WORD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid
);

    logic [1:0]  state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] pc_inc;
    logic [31:0] hold_instr, hold_next;
    logic [31:0] drain_addr, drain_next;
    if_id_t      last, presented;

    assign pc_inc = pc + 32'd4;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        hold_next  = hold_instr;
        drain_next = drain_addr;
        presented  = make_if_id(NOP, 32'd0, 1'b0);
        imem_req   = 1'b0;
        imem_addr  = pc;

        if (!reset) begin
            case (state)
                ST_REQ: begin
                    imem_req = 1'b1;
                    if (redirect) begin
                        pc_next = redirect_pc;
                        // The request cannot be withdrawn, so its late response must be drained.
                        if (!imem_ack) begin
                            drain_next = pc;
                            state_next = ST_DRAIN;
                        end
                    end else if (stall) begin
                        presented = last;
                        if (imem_ack) begin
                            hold_next  = imem_rdata;
                            state_next = ST_HELD;
                        end
                    end else if (imem_ack) begin
                        presented = make_if_id(imem_rdata, pc_inc, 1'b1);
                        pc_next   = pc_inc;
                    end
                end

                ST_HELD: begin
                    if (redirect) begin
                        pc_next    = redirect_pc;
                        state_next = ST_REQ;
                    end else if (stall) begin
                        presented = last;
                    end else begin
                        presented  = make_if_id(hold_instr, pc_inc, 1'b1);
                        pc_next    = pc_inc;
                        state_next = ST_REQ;
                    end
                end

                ST_DRAIN: begin
                    imem_req  = 1'b1;
                    imem_addr = drain_addr;
                    if (redirect) begin
                        pc_next = redirect_pc;
                    end else if (stall) begin
                        presented = last;
                    end
                    if (imem_ack) begin
                        state_next = ST_REQ;
                    end
                end

                default: begin
                    state_next = ST_REQ;
                end
            endcase
        end
    end

    assign instruction = presented.instr;
    assign pc_plus4    = presented.pc4;
    assign fetch_valid = presented.valid;

    // last mirrors what IF/ID captures at each edge, so a stall can re-present it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            state      <= ST_REQ;
            hold_instr <= NOP;
            drain_addr <= 32'd0;
            last       <= make_if_id(NOP, 32'd0, 1'b0);
        end else begin
            pc         <= pc_next;
            state      <= state_next;
            hold_instr <= hold_next;
            drain_addr <= drain_next;
            last       <= presented;
        end
    end

endmodule
